// File: rtl/ad_capture_if.sv
// Converter-side pins and the captured sample stream of the serial ADC front-end.
// The master drives convert/clock/sample outputs; the slave returns serial data.
interface ad_capture_if;
  logic        ad_cnv;
  logic        ad_sck;
  logic        ad_sdo;
  logic [15:0] ad_data;
  logic        ad_vld;

  modport master (
    output ad_cnv,
    output ad_sck,
    output ad_data,
    output ad_vld,
    input  ad_sdo
  );

  modport slave (
    input  ad_cnv,
    input  ad_sck,
    input  ad_data,
    input  ad_vld,
    output ad_sdo
  );
endinterface

// File: rtl/ad_capture.sv
// Serial ADC front-end: paces conversions from the 1 us tick, clocks out a
// 16-bit word MSB first and flags sample periods that land on a busy converter.
module ad_capture #(
  parameter int T_CONV  = 200,
  parameter int SCK_DIV = 4
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         pluse_us,
  input  logic         enable,
  input  logic [7:0]   cfg_period,
  input  logic         clr_miss,
  ad_capture_if.master adc,
  output logic         ad_miss,
  output logic [7:0]   miss_cnt
);

  localparam int CNT_W = $clog2(T_CONV + 1);
  localparam int DIV_W = $clog2(SCK_DIV + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] us_cnt_q, us_cnt_d;
  logic       trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] sreg_q, sreg_d;
  logic [15:0] data_q, data_d;
  logic        miss_q, miss_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic        cnv_q, cnv_d;
  logic        sck_q, sck_d;
  logic        vld_q, vld_d;
  logic [7:0]  period;

  always_comb begin
    period   = (cfg_period == 8'd0) ? 8'd1 : cfg_period;
    us_cnt_d = us_cnt_q;
    trig_d   = 1'b0;
    if (!enable) begin
      us_cnt_d = 8'd0;
    end else if (pluse_us) begin
      if ((9'(us_cnt_q) + 9'd1) >= 9'(period)) begin
        trig_d   = 1'b1;
        us_cnt_d = 8'd0;
      end else begin
        us_cnt_d = us_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    half_d  = half_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    miss_d  = miss_q;
    mcnt_d  = mcnt_q;

    if (clr_miss) begin
      miss_d = 1'b0;
      mcnt_d = 8'd0;
    end
    // A miss in the same cycle as a clear leaves a count of one
    if (trig_q && state_q != IDLE) begin
      miss_d = 1'b1;
      if (clr_miss)
        mcnt_d = 8'd1;
      else if (mcnt_q != 8'hFF)
        mcnt_d = mcnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (trig_q) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(T_CONV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          div_d   = '0;
          half_d  = 5'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (half_q[0] && div_q == '0)
          sreg_d = {sreg_q[14:0], adc.ad_sdo};
        if (div_q == DIV_W'(SCK_DIV - 1)) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          if (half_q == 5'd31) begin
            state_d = DONE;
            data_d  = sreg_d;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Pins are registered from the next-state decode so they never glitch
    cnv_d = (state_d == CONV);
    sck_d = (state_d == SHIFT) && half_d[0];
    vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      us_cnt_q <= 8'd0;
      trig_q   <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      half_q   <= 5'd0;
      sreg_q   <= 16'd0;
      data_q   <= 16'd0;
      miss_q   <= 1'b0;
      mcnt_q   <= 8'd0;
      cnv_q    <= 1'b0;
      sck_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
      trig_q   <= trig_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sreg_q   <= sreg_d;
      data_q   <= data_d;
      miss_q   <= miss_d;
      mcnt_q   <= mcnt_d;
      cnv_q    <= cnv_d;
      sck_q    <= sck_d;
      vld_q    <= vld_d;
    end
  end

  assign adc.ad_cnv  = cnv_q;
  assign adc.ad_sck  = sck_q;
  assign adc.ad_data = data_q;
  assign adc.ad_vld  = vld_q;
  assign ad_miss     = miss_q;
  assign miss_cnt    = mcnt_q;

endmodule
